// File: rtl/f_mult_arbiter.sv
// f_mult_arbiter: shares one floating-point multiplier between N_REQ
// requesters using round-robin arbitration with a single operation in
// flight. The result of each operation is routed back to its issuer.
module f_mult_arbiter #(
  parameter int FLEN  = 64,
  parameter int N_REQ = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req_vld,
  input  logic [N_REQ*FLEN-1:0]   req_a,
  input  logic [N_REQ*FLEN-1:0]   req_b,
  output logic [N_REQ-1:0]        req_rdy,
  output logic [N_REQ-1:0]        resp_vld,
  output logic [FLEN-1:0]         resp_res,
  output logic                    resp_err,
  output logic                    busy,
  output logic [FLEN-1:0]         mul_a,
  output logic [FLEN-1:0]         mul_b,
  output logic                    mul_up_valid,
  input  logic [FLEN-1:0]         mul_res,
  input  logic                    mul_down_vld,
  input  logic                    mul_busy,
  input  logic                    mul_error
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  state_t             r_state;
  state_t             w_next_state;
  logic [IDX_W-1:0]   r_ptr;
  logic [IDX_W-1:0]   r_owner;
  logic [IDX_W-1:0]   w_grant_idx;
  logic               w_found;
  logic               w_grant;
  logic [N_REQ-1:0]   w_owner_onehot;
  logic [N_REQ-1:0]   r_resp_vld;
  logic [FLEN-1:0]    r_resp_res;
  logic               r_resp_err;

  // A grant is only possible while idle and the multiplier is willing to take work.
  assign w_grant        = (r_state == IDLE) && w_found && !mul_busy;
  assign w_owner_onehot = {{(N_REQ-1){1'b0}}, 1'b1} << r_owner;

  assign busy     = (r_state == WAIT);
  assign resp_vld = r_resp_vld;
  assign resp_res = r_resp_res;
  assign resp_err = r_resp_err;

  // State register: one operation in flight between a grant and the multiplier's result.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic: leave IDLE on a grant, return when the result comes back.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (w_grant)      w_next_state = WAIT;
      WAIT:    if (mul_down_vld) w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // Round-robin search starting just after the last winner and wrapping around.
  always_comb begin
    logic [IDX_W:0] w_sum;
    w_found     = 1'b0;
    w_grant_idx = '0;
    w_sum       = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      w_sum = {1'b0, r_ptr} + (IDX_W+1)'(k);
      if (w_sum >= (IDX_W+1)'(N_REQ)) begin
        w_sum = w_sum - (IDX_W+1)'(N_REQ);
      end
      if (!w_found && req_vld[w_sum[IDX_W-1:0]]) begin
        w_found     = 1'b1;
        w_grant_idx = w_sum[IDX_W-1:0];
      end
    end
  end

  // Output logic: the winner's operands go straight to the multiplier in the grant cycle, zero otherwise.
  always_comb begin
    req_rdy      = '0;
    mul_up_valid = 1'b0;
    mul_a        = '0;
    mul_b        = '0;
    if (w_grant) begin
      req_rdy[w_grant_idx] = 1'b1;
      mul_up_valid         = 1'b1;
      mul_a                = req_a[int'(w_grant_idx)*FLEN +: FLEN];
      mul_b                = req_b[int'(w_grant_idx)*FLEN +: FLEN];
    end
  end

  // Bookkeeping: remember the winner for fairness and routing, register the one-cycle result pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr      <= IDX_W'(N_REQ-1);
      r_owner    <= '0;
      r_resp_vld <= '0;
      r_resp_res <= '0;
      r_resp_err <= 1'b0;
    end else begin
      r_resp_vld <= '0;
      if (w_grant) begin
        r_ptr   <= w_grant_idx;
        r_owner <= w_grant_idx;
      end
      if ((r_state == WAIT) && mul_down_vld) begin
        r_resp_vld <= w_owner_onehot;
        r_resp_res <= mul_res;
        r_resp_err <= mul_error;
      end
    end
  end

endmodule
